// File: rtl/raiz_quadrada.sv
// raiz_quadrada: sequential integer square root (restoring, one root bit per clock).
// Returns floor root and remainder of an N_BITS radicand through a start/done handshake.
// Optional build macro RAIZ_ARREDONDA_EN: raiz is rounded to nearest (saturating);
// resto still reports the truncated remainder.
module raiz_quadrada #(
  parameter  int unsigned N_BITS = 14,
  localparam int unsigned W_RAIZ = (N_BITS + 1) / 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BITS-1:0]   radicando,
  output logic [W_RAIZ-1:0]   raiz,
  output logic [W_RAIZ:0]     resto,
  output logic                ocupado,
  output logic                pronto
);

  localparam int unsigned W_RAD = 2 * W_RAIZ;
  localparam int unsigned W_REM = W_RAIZ + 2;
  localparam int unsigned W_CNT = (W_RAIZ > 1) ? $clog2(W_RAIZ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [W_RAD-1:0]    rad_q, rad_d;
  logic [W_REM-1:0]    rem_q, rem_d;
  logic [W_RAIZ-1:0]   root_q, root_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d;
  logic [W_RAIZ-1:0]   raiz_q, raiz_d;
  logic [W_RAIZ:0]     resto_q, resto_d;
  logic                ocupado_q, ocupado_d;
  logic                pronto_q, pronto_d;

  // Single restoring step: bring in the next radicand pair and try (root<<2)|1.
  logic [W_REM-1:0]    rem_sh;
  logic [W_REM-1:0]    trial;
  logic                cabe;
  logic [W_REM-1:0]    rem_nx;
  logic [W_RAIZ-1:0]   root_nx;
  logic [W_RAIZ-1:0]   raiz_fin;

  // Datapath of one digit step plus the value published as raiz on the last step.
  always_comb begin
    rem_sh  = W_REM'({rem_q, rad_q[W_RAD-1 -: 2]});
    trial   = {root_q, 2'b01};
    cabe    = (rem_sh >= trial);
    rem_nx  = cabe ? (rem_sh - trial) : rem_sh;
    root_nx = {root_q[W_RAIZ-2:0], cabe};
`ifdef RAIZ_ARREDONDA_EN
    if ((rem_nx > W_REM'(root_nx)) && !(&root_nx)) begin
      raiz_fin = root_nx + W_RAIZ'(1);
    end else begin
      raiz_fin = root_nx;
    end
`else
    raiz_fin = root_nx;
`endif
  end

  // State and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= IDLE;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      raiz_q    <= '0;
      resto_q   <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      raiz_q    <= raiz_d;
      resto_q   <= resto_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  // Next-state and next-output logic; a start is accepted identically from IDLE and DONE.
  always_comb begin
    estado_d  = estado_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    raiz_d    = raiz_q;
    resto_d   = resto_q;
    ocupado_d = 1'b0;
    pronto_d  = 1'b0;

    unique case (estado_q)
      IDLE, DONE: begin
        if (iniciar) begin
          rad_d     = W_RAD'(radicando);
          rem_d     = '0;
          root_d    = '0;
          cnt_d     = W_CNT'(W_RAIZ - 1);
          ocupado_d = 1'b1;
          estado_d  = CALC;
        end else begin
          estado_d  = IDLE;
        end
      end

      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nx;
        root_d = root_nx;
        if (cnt_q == '0) begin
          raiz_d   = raiz_fin;
          resto_d  = (W_RAIZ + 1)'(rem_nx);
          pronto_d = 1'b1;
          estado_d = DONE;
        end else begin
          cnt_d     = cnt_q - W_CNT'(1);
          ocupado_d = 1'b1;
        end
      end

      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  assign raiz    = raiz_q;
  assign resto   = resto_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_raiz_quadrada.sv
// Scoreboard bench for raiz_quadrada: driver pushes hand-computed results,
// monitor pops and compares on every pronto pulse.
module tb_raiz_quadrada;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [13:0] radicando;
  logic [6:0]  raiz;
  logic [7:0]  resto;
  logic        ocupado;
  logic        pronto;

  raiz_quadrada #(.N_BITS(14)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .radicando (radicando),
    .raiz      (raiz),
    .resto     (resto),
    .ocupado   (ocupado),
    .pronto    (pronto)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [6:0] r;
    logic [7:0] s;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  // Expected published root from the hand-computed floor root and remainder.
  function automatic logic [6:0] rnd(input logic [6:0] r, input logic [7:0] s);
`ifdef RAIZ_ARREDONDA_EN
    if ((s > {1'b0, r}) && (r != 7'd127)) return r + 7'd1;
`endif
    return r;
  endfunction

  // Monitor: result compare, latency, busy-cycle count, exclusivity and hold checks.
  logic [6:0] held_r = '0;
  logic [7:0] held_s = '0;
  int         ocu    = 0;
  always @(negedge clock) begin
    if (reset) begin
      ocu    = 0;
      held_r = '0;
      held_s = '0;
    end else begin
      if (ocupado) ocu++;
      if (ocupado && pronto) chk("ocupado_and_pronto", 1, 0);
      if (pronto) begin
        if (sb.size() == 0) begin
          chk("unexpected_pronto", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("raiz", int'(raiz), int'(e.r));
          chk("resto", int'(resto), int'(e.s));
          chk("latency_cycle", cyc, e.due);
          chk("ocupado_cycles", ocu, 7);
          held_r = e.r;
          held_s = e.s;
        end
        ocu = 0;
      end else begin
        chk("raiz_hold", int'(raiz), int'(held_r));
        chk("resto_hold", int'(resto), int'(held_s));
      end
    end
  end

  task automatic start(input int val, input int r, input int s);
    @(negedge clock);
    iniciar   = 1'b1;
    radicando = 14'(val);
    sb.push_back('{rnd(7'(r), 8'(s)), 8'(s), cyc + 8});
    @(negedge clock);
    iniciar   = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    reset     = 1'b1;
    iniciar   = 1'b0;
    radicando = '0;
    repeat (2) @(negedge clock);
    chk("reset_raiz", int'(raiz), 0);
    chk("reset_resto", int'(resto), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    chk("reset_pronto", int'(pronto), 0);
    reset = 1'b0;

    // Directed vectors: radicand, floor root, remainder.
    start(0, 0, 0);         wait_empty();
    start(3969, 63, 0);     wait_empty();
    start(11907, 109, 26);  wait_empty();
    start(72, 8, 8);        wait_empty();
    start(73, 8, 9);        wait_empty();
    start(16383, 127, 254); wait_empty();
    start(1, 1, 0);         wait_empty();
    start(2, 1, 1);         wait_empty();

    // iniciar held through CALC with changing radicand, then a back-to-back start of 100.
    @(negedge clock);
    iniciar   = 1'b1;
    radicando = 14'd1000;
    sb.push_back('{rnd(7'd31, 8'd39), 8'd39, cyc + 8});
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock);
      radicando = 14'(5000 + i * 111);
    end
    @(negedge clock);
    radicando = 14'd100;
    sb.push_back('{rnd(7'd10, 8'd0), 8'd0, cyc + 8});
    @(negedge clock);
    iniciar = 1'b0;
    wait_empty();

    // Reset in the third CALC cycle discards the pending result.
    @(negedge clock);
    iniciar   = 1'b1;
    radicando = 14'd5000;
    @(negedge clock);
    iniciar   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset_raiz", int'(raiz), 0);
    chk("midreset_resto", int'(resto), 0);
    chk("midreset_ocupado", int'(ocupado), 0);
    chk("midreset_pronto", int'(pronto), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);

    start(50, 7, 1); wait_empty();
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
